// File: rtl/uart_pkg.sv
// Shared UART types: receive-controller state, oversampling ratio, frame size.
// Imported by uart_baud_gen and uart_rx_ctrl.
package uart_pkg;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } rx_ctrl_state_t;

  localparam int OVERSAMPLE = 16;

  // start + data + stop
  function automatic int FRAME_BITS(input int dbit);
    return dbit + 2;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Programmable tick generator: one-cycle tick every div+1 clocks while en.
// Ports: clk, rst (async low), en, div, tick.
module uart_baud_gen #(
  parameter int DIV_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] tcnt;
  logic             tick_q;

  // >= so that lowering div below tcnt wraps on the next cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt   <= '0;
      tick_q <= 1'b0;
    end else if (!en) begin
      tcnt   <= '0;
      tick_q <= 1'b0;
    end else if (tcnt >= div) begin
      tcnt   <= '0;
      tick_q <= 1'b1;
    end else begin
      tcnt   <= tcnt + DIV_W'(1);
      tick_q <= 1'b0;
    end
  end

  // gate so a tick registered on the last enabled cycle never leaks out
  assign tick = tick_q & en;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: tick generation, enable/drain sequencing, byte FIFO.
// Ports: cfg_en/cfg_div, s_tick, rx_done_tick/rx_dout, m_* stream, fifo_count,
// overrun/ovr_clr, rx_timeout (live only with UART_RX_TIMEOUT_EN defined).
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DBIT          = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int DIV_W         = 11,
  parameter int TIMEOUT_CHARS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_en,
  input  logic [DIV_W-1:0]              cfg_div,
  output logic                          s_tick,
  input  logic                          rx_done_tick,
  input  logic [DBIT-1:0]               rx_dout,
  output logic [DBIT-1:0]               m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  input  logic                          ovr_clr,
  output logic                          rx_timeout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int DRAIN_LAST = FRAME_BITS(DBIT) * OVERSAMPLE - 1;
  localparam int DCW = $clog2(DRAIN_LAST + 2);

  rx_ctrl_state_t state_q, state_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic           tick_en;

  assign tick_en = (state_q != OFF);

  uart_baud_gen #(
    .DIV_W (DIV_W)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .en   (tick_en),
    .div  (cfg_div),
    .tick (s_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= OFF;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // DRAIN waits out one full frame of ticks so an in-flight byte can land
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    unique case (state_q)
      OFF: begin
        dcnt_d = '0;
        if (cfg_en)
          state_d = ACTIVE;
      end
      ACTIVE: begin
        if (!cfg_en) begin
          state_d = DRAIN;
          dcnt_d  = '0;
        end
      end
      DRAIN: begin
        if (s_tick)
          dcnt_d = dcnt_q + DCW'(1);
        if (cfg_en)
          state_d = ACTIVE;
        else if (rx_done_tick ||
                 (s_tick && dcnt_q == DCW'(DRAIN_LAST)))
          state_d = OFF;
      end
      default: begin
        state_d = OFF;
        dcnt_d  = '0;
      end
    endcase
  end

  logic [DBIT-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [CW-1:0]   count;
  logic            push_req, push, pop, full, drop;

  assign push_req = rx_done_tick && tick_en;
  assign full     = (count == CW'(FIFO_DEPTH));
  assign pop      = m_valid && m_ready;
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  assign m_valid    = (count != '0);
  assign m_data     = mem[rptr];
  assign fifo_count = count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= rx_dout;
        wptr      <= wptr + AW'(1);
      end
      if (pop)
        rptr <= rptr + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      count <= '0;
    else begin
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // set beats clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      overrun <= 1'b0;
    else if (drop)
      overrun <= 1'b1;
    else if (ovr_clr)
      overrun <= 1'b0;
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam int TO_LIMIT = TIMEOUT_CHARS * FRAME_BITS(DBIT) * OVERSAMPLE;
  localparam int IW = $clog2(TO_LIMIT + 1);

  logic [IW-1:0] icnt;
  logic          to_q;

  // saturating at TO_LIMIT keeps the pulse single until the next clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      icnt <= '0;
      to_q <= 1'b0;
    end else begin
      to_q <= 1'b0;
      if (push_req || count == '0)
        icnt <= '0;
      else if (s_tick && icnt < IW'(TO_LIMIT)) begin
        icnt <= icnt + IW'(1);
        if (icnt == IW'(TO_LIMIT - 1))
          to_q <= 1'b1;
      end
    end
  end

  assign rx_timeout = to_q;
`else
  assign rx_timeout = 1'b0;
`endif

endmodule
